// File: rtl/spec_mem_pkg.sv
// Shared types and default sizing for the SPECDATA memory arbiter.
package spec_mem_pkg;

  localparam int DEF_DATA_W     = 16;
  localparam int DEF_ADDR_W     = 8;
  localparam int DEF_SPEC_WORDS = 131;
  localparam int DEF_LEN_W      = 4;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HW_BURST = 2'd1,
    SW_ACC   = 2'd2
  } state_t;

  // Owner of the most recent grant, used for alternating fairness
  typedef enum logic {
    OWNER_HW = 1'b0,
    OWNER_SW = 1'b1
  } owner_t;

endpackage

// File: rtl/spec_burst_addr_gen.sv
// Burst address generator: holds the address of the beat currently on the
// memory port, offers the following address (wrapping at the table end) and
// flags when the current beat is the final one of the burst.
module spec_burst_addr_gen
  import spec_mem_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int LEN_W      = DEF_LEN_W,
  parameter int SPEC_WORDS = DEF_SPEC_WORDS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [LEN_W-1:0]  len,
  input  logic              step,
  output logic [ADDR_W-1:0] next_addr,
  output logic              last
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SPEC_WORDS - 1);
  localparam logic [LEN_W:0]    BEAT_INC  = (LEN_W+1)'(1);

  logic [ADDR_W-1:0] addr_reg;
  logic [LEN_W:0]    beat_reg;   // one bit wider than len so 16 beats never overflow
  logic [LEN_W-1:0]  len_reg;

  assign next_addr = (addr_reg == LAST_ADDR) ? '0 : addr_reg + ADDR_W'(1);
  assign last      = (beat_reg == {1'b0, len_reg});

  // Load the burst descriptor on grant, advance one beat per step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_reg <= '0;
      beat_reg <= '0;
      len_reg  <= '0;
    end else if (load) begin
      addr_reg <= start_addr;
      beat_reg <= '0;
      len_reg  <= len;
    end else if (step) begin
      addr_reg <= next_addr;
      beat_reg <= beat_reg + BEAT_INC;
    end
  end

endmodule

// File: rtl/spec_mem_arbiter.sv
// Arbiter sharing the single-port SPECDATA memory between the CFA path
// matcher (read bursts) and the TCB (single reads/writes). Alternates on
// ties, rejects out-of-range addresses and keeps non-TCB writes off the port.
module spec_mem_arbiter
  import spec_mem_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int SPEC_WORDS = DEF_SPEC_WORDS,
  parameter int LEN_W      = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hw_req,
  input  logic [ADDR_W-1:0] hw_addr,
  input  logic [LEN_W-1:0]  hw_len,
  output logic              hw_gnt,
  output logic              hw_rvalid,
  output logic [DATA_W-1:0] hw_rdata,
  output logic              hw_done,
  output logic              hw_err,
  input  logic              sw_req,
  input  logic              sw_we,
  input  logic [ADDR_W-1:0] sw_addr,
  input  logic [DATA_W-1:0] sw_wdata,
  input  logic              sw_in_tcb,
  output logic              sw_gnt,
  output logic              sw_rvalid,
  output logic [DATA_W-1:0] sw_rdata,
  output logic              sw_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SPEC_WORDS - 1);

  state_t state_reg, state_next;
  owner_t last_owner_reg, last_owner_next;

  logic hw_win, sw_win, hw_bad, sw_bad;
  logic gen_load, gen_step, gen_last;
  logic [ADDR_W-1:0] gen_next_addr;
  logic [LEN_W-1:0]  gen_len;

  logic hw_gnt_reg, hw_rvalid_reg, hw_done_reg, hw_err_reg;
  logic sw_gnt_reg, sw_rvalid_reg, sw_err_reg;
  logic mem_en_reg, mem_we_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic [DATA_W-1:0] mem_wdata_reg;

  logic hw_gnt_next, hw_rvalid_next, hw_done_next, hw_err_next;
  logic sw_gnt_next, sw_rvalid_next, sw_err_next;
  logic mem_en_next, mem_we_next;
  logic [ADDR_W-1:0] mem_addr_next;
  logic [DATA_W-1:0] mem_wdata_next;

  // Arbitration only in IDLE; on a tie the master that did not own the last grant wins
  assign hw_win = (state_reg == IDLE) && hw_req &&
                  (!sw_req || (last_owner_reg == OWNER_SW));
  assign sw_win = (state_reg == IDLE) && sw_req && !hw_win;

  assign hw_bad = (hw_addr > LAST_ADDR);
  assign sw_bad = (sw_addr > LAST_ADDR) || (sw_we && !sw_in_tcb);

  // A rejected burst is loaded as a single beat so HW_BURST exits after one cycle
  assign gen_load = hw_win;
  assign gen_len  = hw_bad ? '0 : hw_len;
  assign gen_step = (state_reg == HW_BURST) && !gen_last;

  spec_burst_addr_gen #(
    .ADDR_W     (ADDR_W),
    .LEN_W      (LEN_W),
    .SPEC_WORDS (SPEC_WORDS)
  ) u_addr_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (gen_load),
    .start_addr (hw_addr),
    .len        (gen_len),
    .step       (gen_step),
    .next_addr  (gen_next_addr),
    .last       (gen_last)
  );

  // State and fairness register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      last_owner_reg <= OWNER_SW;
    end else begin
      state_reg      <= state_next;
      last_owner_reg <= last_owner_next;
    end
  end

  // Next-state: busy states always return to IDLE once their last issue is on the port
  always_comb begin
    state_next      = state_reg;
    last_owner_next = last_owner_reg;
    case (state_reg)
      IDLE: begin
        if (hw_win) begin
          state_next      = HW_BURST;
          last_owner_next = OWNER_HW;
        end else if (sw_win) begin
          state_next      = SW_ACC;
          last_owner_next = OWNER_SW;
        end
      end
      HW_BURST: if (gen_last) state_next = IDLE;
      SW_ACC:   state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Output decode: next values of every registered output
  always_comb begin
    hw_gnt_next    = 1'b0;
    hw_rvalid_next = 1'b0;
    hw_done_next   = 1'b0;
    hw_err_next    = 1'b0;
    sw_gnt_next    = 1'b0;
    sw_rvalid_next = 1'b0;
    sw_err_next    = 1'b0;
    mem_en_next    = 1'b0;
    mem_we_next    = 1'b0;
    mem_addr_next  = '0;
    mem_wdata_next = '0;
    case (state_reg)
      IDLE: begin
        if (hw_win) begin
          hw_gnt_next = 1'b1;
          if (hw_bad) begin
            hw_err_next  = 1'b1;
            hw_done_next = 1'b1;
          end else begin
            mem_en_next   = 1'b1;
            mem_addr_next = hw_addr;
          end
        end else if (sw_win) begin
          sw_gnt_next = 1'b1;
          if (sw_bad) begin
            sw_err_next = 1'b1;
          end else begin
            mem_en_next    = 1'b1;
            mem_we_next    = sw_we;
            mem_addr_next  = sw_addr;
            mem_wdata_next = sw_wdata;
          end
        end
      end
      HW_BURST: begin
        // Read data for the beat on the port now appears next cycle
        hw_rvalid_next = mem_en_reg;
        hw_done_next   = mem_en_reg && gen_last;
        if (!gen_last) begin
          mem_en_next   = 1'b1;
          mem_addr_next = gen_next_addr;
        end
      end
      SW_ACC: begin
        sw_rvalid_next = mem_en_reg && !mem_we_reg;
      end
      default: ;
    endcase
  end

  // Output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hw_gnt_reg    <= 1'b0;
      hw_rvalid_reg <= 1'b0;
      hw_done_reg   <= 1'b0;
      hw_err_reg    <= 1'b0;
      sw_gnt_reg    <= 1'b0;
      sw_rvalid_reg <= 1'b0;
      sw_err_reg    <= 1'b0;
      mem_en_reg    <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
    end else begin
      hw_gnt_reg    <= hw_gnt_next;
      hw_rvalid_reg <= hw_rvalid_next;
      hw_done_reg   <= hw_done_next;
      hw_err_reg    <= hw_err_next;
      sw_gnt_reg    <= sw_gnt_next;
      sw_rvalid_reg <= sw_rvalid_next;
      sw_err_reg    <= sw_err_next;
      mem_en_reg    <= mem_en_next;
      mem_we_reg    <= mem_we_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
    end
  end

  assign hw_gnt    = hw_gnt_reg;
  assign hw_rvalid = hw_rvalid_reg;
  assign hw_done   = hw_done_reg;
  assign hw_err    = hw_err_reg;
  assign sw_gnt    = sw_gnt_reg;
  assign sw_rvalid = sw_rvalid_reg;
  assign sw_err    = sw_err_reg;
  assign mem_en    = mem_en_reg;
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;

  // Read data is shared; the rvalid strobes say whose it is
  assign hw_rdata = mem_rdata;
  assign sw_rdata = mem_rdata;

endmodule
